// File: rtl/seg7_pkg.sv
// seg7_pkg: display codes and converter state shared with the seven-segment driver
package seg7_pkg;
  localparam logic [3:0] BLANK_CODE = 4'd15;
  localparam logic [3:0] OVF_CODE = 4'd10;
  localparam int NUM_DIGITS = 4;
  localparam int ACC_W = 20;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} conv_state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit adjust, adds 3 to any digit of 5 or more
module bcd_add3 (
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);
  always_comb d_out = d_in >= 4'd5 ? d_in + 4'd3 : d_in;
endmodule

// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display: iterative binary to four-digit BCD with blanking and overflow
module bin_to_bcd_display
  import seg7_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             blank_lz,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [3:0]       bcd_data_0,
  output logic [3:0]       bcd_data_1,
  output logic [3:0]       bcd_data_2,
  output logic [3:0]       bcd_data_3
);
  localparam int CW = $clog2(WIDTH + 1);
  conv_state_t state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic [ACC_W-1:0] acc, adj;
  logic [CW-1:0] cnt;
  logic blz, ovf, z3, z2, z1;
  logic [15:0] fin;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.d_in(acc[4*i +: 4]), .d_out(adj[4*i +: 4]));
  end
  // digit 4 only collects the overflow and never needs adjusting for WIDTH<=16
  assign adj[19:16] = acc[19:16];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = clear ? IDLE :
                state == IDLE ? (start ? SHIFT : IDLE) :
                state == SHIFT ? (cnt == CW'(1) ? FINISH : SHIFT) : IDLE;
  always_comb begin
    busy = state != IDLE;
    ovf = acc[19:16] != 4'd0;
    z3 = acc[15:12] == 4'd0;
    z2 = z3 && acc[11:8] == 4'd0;
    z1 = z2 && acc[7:4] == 4'd0;
    fin[15:12] = ovf ? OVF_CODE : blz && z3 ? BLANK_CODE : acc[15:12];
    fin[11:8] = ovf ? OVF_CODE : blz && z2 ? BLANK_CODE : acc[11:8];
    fin[7:4] = ovf ? OVF_CODE : blz && z1 ? BLANK_CODE : acc[7:4];
    fin[3:0] = ovf ? OVF_CODE : acc[3:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      acc <= '0;
      cnt <= '0;
      blz <= 1'b0;
      done <= 1'b0;
      valid <= 1'b0;
      {bcd_data_3, bcd_data_2, bcd_data_1, bcd_data_0} <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        valid <= 1'b0;
        {bcd_data_3, bcd_data_2, bcd_data_1, bcd_data_0} <= {4{BLANK_CODE}};
      end else if (state == IDLE && start) begin
        sh <= bin_in;
        blz <= blank_lz;
        acc <= '0;
        cnt <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        {acc, sh} <= {adj, sh} << 1;
        cnt <= cnt - 1'b1;
      end else if (state == FINISH) begin
        {bcd_data_3, bcd_data_2, bcd_data_1, bcd_data_0} <= fin;
        done <= 1'b1;
        valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// tb_bin_to_bcd_display: randomized check of the converter against an arithmetic model
module tb_bin_to_bcd_display;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, clear = 1'b0, blank_lz = 1'b0;
  logic [W-1:0] bin_in = '0;
  logic busy, done, valid;
  logic [3:0] bcd_data_0, bcd_data_1, bcd_data_2, bcd_data_3;
  logic [15:0] dut_dig;
  int compared = 0, mismatched = 0;
  bit chk_en = 1'b0;
  int m_rem = 0, m_val = 0;
  bit m_done = 1'b0, m_valid = 1'b0, m_blz = 1'b0;
  logic [15:0] m_dig = '0;
  bin_to_bcd_display #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .blank_lz(blank_lz),
    .bin_in(bin_in), .busy(busy), .done(done), .valid(valid),
    .bcd_data_0(bcd_data_0), .bcd_data_1(bcd_data_1),
    .bcd_data_2(bcd_data_2), .bcd_data_3(bcd_data_3)
  );
  assign dut_dig = {bcd_data_3, bcd_data_2, bcd_data_1, bcd_data_0};
  always #5 clk = ~clk;
  function automatic logic [15:0] model_digits(input int v, input bit b);
    logic [3:0] d [4];
    if (v > 9999) return 16'hAAAA;
    for (int i = 0; i < 4; i++) begin
      d[i] = 4'(v % 10);
      v = v / 10;
    end
    if (b)
      for (int i = 3; i > 0; i--) begin
        if (d[i] != 4'd0) break;
        d[i] = 4'd15;
      end
    return {d[3], d[2], d[1], d[0]};
  endfunction
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a conversion is just a countdown of WIDTH+1 cycles ending in the decimal result
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_rem <= 0;
      m_done <= 1'b0;
      m_valid <= 1'b0;
      m_dig <= '0;
      m_val <= 0;
      m_blz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (clear) begin
        m_rem <= 0;
        m_valid <= 1'b0;
        m_dig <= 16'hFFFF;
      end else if (m_rem == 0) begin
        if (start) begin
          m_rem <= W + 1;
          m_val <= int'(bin_in);
          m_blz <= blank_lz;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_valid <= 1'b1;
          m_dig <= model_digits(m_val, m_blz);
        end
      end
    end
  always @(negedge clk)
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(m_rem != 0));
      cmp("done", 32'(done), 32'(m_done));
      cmp("valid", 32'(valid), 32'(m_valid));
      cmp("digits", 32'(dut_dig), 32'(m_dig));
    end
  task automatic run(input int v, input bit b, input logic [15:0] exp);
    int lat;
    @(negedge clk);
    bin_in = W'(v);
    blank_lz = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    cmp("latency", 32'(lat), 32'(W + 1));
    cmp("lit_digits", 32'(dut_dig), 32'(exp));
    cmp("lit_valid", 32'(valid), 32'd1);
  endtask
  task automatic count_done(input int cycles, input int exp, input string name);
    int n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) n++;
    end
    cmp(name, 32'(n), 32'(exp));
  endtask
  initial begin
    int sel;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_valid", 32'(valid), 32'd0);
    cmp("rst_digits", 32'(dut_dig), 32'd0);
    rst_n = 1'b1;
    run(1234, 1'b0, 16'h1234);
    run(7, 1'b1, 16'hFFF7);
    run(0, 1'b1, 16'hFFF0);
    run(105, 1'b1, 16'hF105);
    run(9999, 1'b0, 16'h9999);
    run(10000, 1'b0, 16'hAAAA);
    run(65535, 1'b1, 16'hAAAA);
    @(negedge clk);
    bin_in = W'(321);
    blank_lz = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    bin_in = W'(999);
    blank_lz = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_done(25, 1, "restart_dones");
    cmp("restart_digits", 32'(dut_dig), 32'h0321);
    @(negedge clk);
    bin_in = W'(4321);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    cmp("clr_busy", 32'(busy), 32'd0);
    cmp("clr_valid", 32'(valid), 32'd0);
    cmp("clr_digits", 32'(dut_dig), 32'hFFFF);
    count_done(25, 0, "clr_dones");
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    cmp("clr_start_busy", 32'(busy), 32'd0);
    count_done(20, 0, "clr_start_dones");
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sel = $urandom_range(0, 3);
      bin_in = sel == 0 ? W'($urandom) : sel == 1 ? W'($urandom_range(0, 9999)) :
               sel == 2 ? W'($urandom_range(0, 99)) : W'($urandom_range(9990, 10010));
      blank_lz = 1'($urandom_range(0, 1));
      start = $urandom_range(0, 3) == 0;
      clear = $urandom_range(0, 59) == 0;
    end
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    repeat (20) @(negedge clk);
    bin_in = W'(5555);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("midrst_busy", 32'(busy), 32'd0);
    cmp("midrst_done", 32'(done), 32'd0);
    cmp("midrst_valid", 32'(valid), 32'd0);
    cmp("midrst_digits", 32'(dut_dig), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(42, 1'b0, 16'h0042);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_display.md
# bin_to_bcd_display

Iterative binary-to-BCD converter that sits directly upstream of the four-digit seven-segment driver. Accepts an unsigned binary value with a start pulse, converts it with a shift-and-add-3 (double-dabble) sequence, and presents four registered BCD digits plus a `valid` flag in exactly the format the driver consumes. It applies optional leading-zero blanking (code 15) and an overflow pattern (code 10, rendered as "F") for values above 9999.

## Interface
- `WIDTH`, 16, bit width of `bin_in`; legal range 4..16.
- `clk  input  1  clock`
- `rst_n  input  1  reset, asynchronous, active-low`
- `start  input  1  single-cycle request; sampled only in IDLE`
- `clear  input  1  synchronous abort/blank; drops `valid`, returns to IDLE`
- `blank_lz  input  1  leading-zero blanking enable; latched with `start``
- `bin_in  input  WIDTH  unsigned value; latched with `start``
- `busy  output  1  high while a conversion is in progress`
- `done  output  1  one-cycle pulse when new digits are loaded`
- `valid  output  1  digits hold a completed result`
- `bcd_data_0..bcd_data_3  output  4 each  digit 0 = least significant (rightmost) … digit 3 = most significant`

## Operation
- FSM states: IDLE, SHIFT, FINISH.
- IDLE: `start`=1 and `clear`=0 → latch `bin_in` into shift register, latch `blank_lz`, zero the 20-bit BCD accumulator (5 digits), load iteration counter with WIDTH, go to SHIFT.
- SHIFT: each cycle, every accumulator digit ≥5 gets +3, then {accumulator, shift reg} shifts left one bit; counter decrements; after WIDTH iterations go to FINISH.
- FINISH: accumulator digit 4 ≠ 0 → overflow, all four outputs = 10. Otherwise outputs = digits 0..3; if latched `blank_lz`=1, leading zeros in digits 3, 2, 1 (scanning from digit 3 downward, stopping at the first nonzero digit) are replaced by 15. Digit 0 is never blanked. Pulse `done`, set `valid`, return to IDLE.
- `start` in SHIFT or FINISH is ignored; it is not queued.
- `clear`: in any state → IDLE next cycle, `valid`←0, `done` not pulsed, digits←15. `clear` and `start` in the same cycle: `clear` wins.
- Outputs hold their previous result during a new conversion. `valid` stays 1 through a re-conversion and is only dropped by `clear`/reset.

## Timing
- Reset (async): state IDLE; `busy`=0, `done`=0, `valid`=0, all `bcd_data_*`=0; accumulator and counter cleared.
- `start` sampled at edge k → `busy`=1 after edge k; SHIFT occupies edges k+1..k+WIDTH; FINISH registers digits at edge k+WIDTH+1, where `done`=1 for exactly one cycle, `valid`=1, and `busy`=0.
- Latency start→done is WIDTH+1 cycles (17 for WIDTH=16) and does not depend on the data value or on overflow.
- Earliest accepted restart is the cycle after `done`.
- Reset mid-conversion aborts immediately; there is no partial output.
- Width rules: accumulator is 20 bits (sufficient for 65535); add-3 applies only to digits 0..3 (digit 4 can never reach 5 before the last shift for WIDTH≤16); comparison against overflow uses digit 4 only.

## Structure
- Shared package `seg7_pkg`: `BLANK_CODE`=4'd15, `OVF_CODE`=4'd10, `NUM_DIGITS`=4, state enum `conv_state_t` {IDLE, SHIFT, FINISH}. The display driver uses the same codes.
- One natural sub-module, `bcd_add3`: combinational 4-bit digit adjust (≥5 → +3), instantiated per accumulator digit.

## Test plan
- `bin_in`=1234, `blank_lz`=0, `start` pulse → `done` 17 cycles later; digits 0..3 = 4,3,2,1; `valid`=1.
- `bin_in`=7, `blank_lz`=1 → digits 0..3 = 7,15,15,15. `bin_in`=0, `blank_lz`=1 → 0,15,15,15. `bin_in`=105, `blank_lz`=1 → 5,0,1,15.
- `bin_in`=9999 → 9,9,9,9. `bin_in`=10000 and `bin_in`=65535 → 10,10,10,10, each with the same 17-cycle latency.
- `start` re-pulsed 5 cycles into a conversion with a different `bin_in` → ignored; the result matches the first value; exactly one `done` pulse.
- `clear` at cycle 8 of a conversion → `busy`=0 next cycle, `valid`=0, digits = 15, no `done`. `clear`+`start` in the same cycle → conversion not started.
- `rst_n` asserted mid-SHIFT → all outputs 0 immediately. After release, a new conversion of 42 produces 2,4,0,0 (`blank_lz`=0).
